// File: rtl/rv32_pkg.sv
// rv32_pkg: instruction-type codes, sequencer state encoding and pc/wb select codes shared with the decoder
package rv32_pkg;
  typedef enum logic [3:0] {
    IT_OP, IT_OPIMM, IT_BRANCH, IT_LUI, IT_JAL, IT_JALR, IT_LOAD, IT_STORE, IT_AUIPC, IT_UNSUP
  } itype_e;
  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXECUTE, S_MEM, S_WB, S_TRAP} state_e;
  localparam logic [1:0] PC_PLUS4 = 2'd0;
  localparam logic [1:0] PC_IMM = 2'd1;
  localparam logic [1:0] PC_JALR = 2'd2;
  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_LOAD = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;
  localparam logic [1:0] WB_IMM = 2'd3;
endpackage

// File: rtl/mem_handshake_timer.sv
// mem_handshake_timer: holds req while active, drops it for one cycle after TIMEOUT unacked req cycles
module mem_handshake_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic active,
  input  logic ack,
  output logic req
);
  localparam int CW = $clog2(TIMEOUT);
  logic [CW-1:0] cnt_q, cnt_d;
  logic gap_q, gap_d, last;
  // an ack in the last allowed cycle completes the transfer, so only an unacked last cycle opens the gap
  always_comb begin
    req = active & ~gap_q;
    last = cnt_q == CW'(TIMEOUT - 1);
    gap_d = req & ~ack & last;
    cnt_d = (req & ~ack & ~last) ? cnt_q + 1'b1 : '0;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      gap_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      gap_q <= gap_d;
    end
  end
endmodule

// File: rtl/multicycle_control_fsm.sv
// multicycle_control_fsm: RV32I fetch/decode/execute/mem/writeback sequencer; ILLEGAL_TRAP_EN enables sticky trap on unsupported ops
module multicycle_control_fsm
  import rv32_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       iType,
  input  logic             werf,
  input  logic             brTaken,
  input  logic             imem_ack,
  input  logic             dmem_ack,
  output logic             imem_req,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             ir_we,
  output logic             pc_we,
  output logic [1:0]       pc_sel,
  output logic             rf_we,
  output logic [1:0]       wb_sel,
  output logic [2:0]       state_out,
  output logic             retire,
  output logic [CNT_W-1:0] instret,
  output logic             trap
);
  state_e state_q, state_d;
  logic [CNT_W-1:0] instret_q, instret_d;
  logic req, mem_active, mem_ack;
  logic is_br, is_ld, is_st, is_jal, is_jalr, is_lui, is_alu;
  assign mem_active = ~reset & (state_q == S_FETCH | state_q == S_MEM);
  assign mem_ack = (state_q == S_MEM) ? dmem_ack : imem_ack;
  mem_handshake_timer #(.TIMEOUT(MEM_TIMEOUT)) u_timer (
    .clk(clk), .reset(reset), .active(mem_active), .ack(mem_ack), .req(req)
  );
  always_comb begin
    is_br = iType == IT_BRANCH;
    is_ld = iType == IT_LOAD;
    is_st = iType == IT_STORE;
    is_jal = iType == IT_JAL;
    is_jalr = iType == IT_JALR;
    is_lui = iType == IT_LUI;
    is_alu = iType inside {IT_OP, IT_OPIMM, IT_LUI, IT_AUIPC, IT_JAL, IT_JALR};
  end
  // all enables are Mealy on state plus ack/iType/brTaken and forced low while reset is held
  always_comb begin
    state_d = state_q;
    imem_req = 1'b0;
    dmem_req = 1'b0;
    dmem_we = 1'b0;
    ir_we = 1'b0;
    pc_we = 1'b0;
    pc_sel = PC_PLUS4;
    rf_we = 1'b0;
    wb_sel = WB_ALU;
    retire = 1'b0;
    if (!reset) begin
      case (state_q)
        S_FETCH: begin
          imem_req = req;
          ir_we = req & imem_ack;
          state_d = ir_we ? S_DECODE : S_FETCH;
        end
        S_DECODE: state_d = S_EXECUTE;
        S_EXECUTE: begin
          if (is_br) begin
            pc_we = 1'b1;
            pc_sel = brTaken ? PC_IMM : PC_PLUS4;
            retire = 1'b1;
            state_d = S_FETCH;
          end else if (is_ld | is_st) begin
            state_d = S_MEM;
          end else if (is_alu) begin
            state_d = S_WB;
          end else begin
`ifdef ILLEGAL_TRAP_EN
            state_d = S_TRAP;
`else
            pc_we = 1'b1;
            retire = 1'b1;
            state_d = S_FETCH;
`endif
          end
        end
        S_MEM: begin
          dmem_req = req;
          dmem_we = req & is_st;
          pc_we = req & dmem_ack & is_st;
          retire = pc_we;
          state_d = (req & dmem_ack) ? (is_st ? S_FETCH : S_WB) : S_MEM;
        end
        S_WB: begin
          rf_we = werf;
          wb_sel = is_ld ? WB_LOAD : (is_jal | is_jalr) ? WB_PC4 : is_lui ? WB_IMM : WB_ALU;
          pc_sel = is_jal ? PC_IMM : is_jalr ? PC_JALR : PC_PLUS4;
          pc_we = 1'b1;
          retire = 1'b1;
          state_d = S_FETCH;
        end
        default: state_d = state_q;
      endcase
    end
    instret_d = instret_q + CNT_W'(retire);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      instret_q <= '0;
    end else begin
      state_q <= state_d;
      instret_q <= instret_d;
    end
  end
  assign state_out = reset ? 3'd0 : state_q;
  assign instret = reset ? '0 : instret_q;
`ifdef ILLEGAL_TRAP_EN
  assign trap = ~reset & (state_q == S_TRAP);
`else
  assign trap = 1'b0;
`endif
endmodule

// File: tb/tb_multicycle_control_fsm.sv
// tb_multicycle_control_fsm: per-cycle scoreboard of expected control outputs for multicycle_control_fsm
module tb_multicycle_control_fsm;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [3:0] iType = '0;
  logic werf = 1'b0, brTaken = 1'b0, imem_ack = 1'b0, dmem_ack = 1'b0;
  logic imem_req, dmem_req, dmem_we, ir_we, pc_we, rf_we, retire, trap;
  logic [1:0] pc_sel, wb_sel;
  logic [2:0] state_out;
  logic [3:0] instret;
  logic [3:0] n = '0;
  int checks = 0, errors = 0;
  typedef struct {
    string tag;
    logic [14:0] v;
    logic [3:0] r;
  } exp_t;
  exp_t sb[$];
  multicycle_control_fsm #(.MEM_TIMEOUT(4), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .iType(iType), .werf(werf), .brTaken(brTaken),
    .imem_ack(imem_ack), .dmem_ack(dmem_ack), .imem_req(imem_req), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .ir_we(ir_we), .pc_we(pc_we), .pc_sel(pc_sel), .rf_we(rf_we),
    .wb_sel(wb_sel), .state_out(state_out), .retire(retire), .instret(instret), .trap(trap)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [14:0] ev(input logic [2:0] st, input logic im, input logic dm,
                                     input logic dw, input logic ir, input logic pw,
                                     input logic [1:0] ps, input logic rw, input logic [1:0] ws,
                                     input logic rt, input logic tr);
    return {st, im, dm, dw, ir, pw, ps, rw, ws, rt, tr};
  endfunction
  task automatic cyc(input string tag, input logic [14:0] v);
    exp_t e, x;
    e.tag = tag;
    e.v = v;
    e.r = reset ? 4'd0 : n;
    sb.push_back(e);
    if (reset) n = '0;
    else if (v[1]) n = n + 4'd1;
    @(negedge clk);
    x = sb.pop_front();
    check({x.tag, "_out"}, 64'({state_out, imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_sel,
                                rf_we, wb_sel, retire, trap}), 64'(x.v));
    check({x.tag, "_cnt"}, 64'(instret), 64'(x.r));
    @(posedge clk);
    #1;
  endtask
  task automatic fetch_decode(input string tag, input logic [3:0] it, input logic w);
    iType = it;
    werf = w;
    imem_ack = 1'b1;
    cyc({tag, "_f"}, ev(0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    imem_ack = 1'b0;
    cyc({tag, "_d"}, ev(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
  endtask
  initial begin
    cyc("rst0", '0);
    cyc("rst1", '0);
    reset = 1'b0;
    fetch_decode("add", 4'd0, 1'b1);
    cyc("add_e", ev(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    cyc("add_wb", ev(4, 0, 0, 0, 0, 1, 0, 1, 0, 1, 0));
    brTaken = 1'b1;
    fetch_decode("beq_t", 4'd2, 1'b0);
    cyc("beq_t_e", ev(2, 0, 0, 0, 0, 1, 1, 0, 0, 1, 0));
    brTaken = 1'b0;
    fetch_decode("beq_n", 4'd2, 1'b0);
    cyc("beq_n_e", ev(2, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0));
    fetch_decode("jal", 4'd4, 1'b1);
    cyc("jal_e", ev(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    cyc("jal_wb", ev(4, 0, 0, 0, 0, 1, 1, 1, 2, 1, 0));
    fetch_decode("lw", 4'd6, 1'b1);
    dmem_ack = 1'b1;
    cyc("lw_e", ev(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    dmem_ack = 1'b0;
    for (int i = 0; i < 3; i++) cyc("lw_mem", ev(3, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    dmem_ack = 1'b1;
    cyc("lw_ack", ev(3, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    dmem_ack = 1'b0;
    cyc("lw_wb", ev(4, 0, 0, 0, 0, 1, 0, 1, 1, 1, 0));
    fetch_decode("sw", 4'd7, 1'b0);
    cyc("sw_e", ev(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 4; i++) cyc("sw_try", ev(3, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0));
    dmem_ack = 1'b1;
    cyc("sw_gap", ev(3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    dmem_ack = 1'b0;
    for (int i = 0; i < 3; i++) cyc("sw_retry", ev(3, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0));
    dmem_ack = 1'b1;
    cyc("sw_ack", ev(3, 0, 1, 1, 0, 1, 0, 0, 0, 1, 0));
    dmem_ack = 1'b0;
    fetch_decode("ill", 4'd9, 1'b0);
`ifdef ILLEGAL_TRAP_EN
    cyc("ill_e", ev(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    imem_ack = 1'b1;
    for (int i = 0; i < 3; i++) cyc("ill_trap", ev(5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    imem_ack = 1'b0;
    reset = 1'b1;
    cyc("rst_trap", '0);
    reset = 1'b0;
`else
    cyc("ill_e", ev(2, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0));
`endif
    fetch_decode("lw2", 4'd6, 1'b1);
    cyc("lw2_e", ev(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    cyc("lw2_mem", ev(3, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    reset = 1'b1;
    cyc("rst_mem", '0);
    reset = 1'b0;
    cyc("post_rst", ev(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 17; i++) begin
      brTaken = i[0];
      fetch_decode("wrap", 4'd2, 1'b0);
      cyc("wrap_e", ev(2, 0, 0, 0, 0, 1, {1'b0, i[0]}, 0, 0, 1, 0));
    end
    cyc("end_f", ev(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
